// File: rtl/scmp_bus_pkg.sv
// rtl/scmp_bus_pkg.sv - shared types and constants for the SC/MP bus controller
//
// Holds the bus FSM state encoding, the bit positions of the latched
// {H,D,I,R} status flags, the page index width and the bank size.
package scmp_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        CAPTURE,
        DONE
    } bus_state_t;

    // Bit positions inside the latched flags nibble
    localparam int FLAG_H = 3;
    localparam int FLAG_D = 2;
    localparam int FLAG_I = 1;
    localparam int FLAG_R = 0;

    localparam int PAGE_W    = 4;
    localparam int BANK_SIZE = 4096;

endpackage

// File: rtl/scmp_bus_ctrl.sv
// rtl/scmp_bus_ctrl.sv - SC/MP external bus controller for synchronous on-chip banks
//
// Sits between the scmp core and N_BANKS synchronous 4 KiB memories.
// The page nibble and {H,D,I,R} flags are latched on every ADS_n strobe;
// each read/write strobe becomes a single registered rden/wren pulse
// after a per-direction wait, with hold_n stretching the CPU cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_ads_n           address strobe, cpu_d_o = {H,D,I,R,page}
//   cpu_rd_n, cpu_wr_n  active-low read / write strobes
//   cpu_addr[11:0]      low address within the page
//   cpu_d_o[7:0]        CPU data out
//   cpu_d_i[7:0]        registered read data to CPU
//   hold_n              low = CPU must extend the cycle
//   mem_addr, mem_d     registered address / write data to all banks
//   mem_sel[N_BANKS]    one-hot bank select, valid with rden/wren
//   mem_rden, mem_wren  one-cycle read / write pulses
//   mem_q               bank read data, bank i at [8i+7:8i]
//   flags[3:0]          latched {H,D,I,R}
//   bus_err, err_clr    sticky error flag and its clear
module scmp_bus_ctrl
    import scmp_bus_pkg::*;
#(
    parameter int          N_BANKS  = 4,
    parameter logic [15:0] RAM_MASK = 16'h000A,
    parameter int          WAIT_W   = 3,
    parameter int          RD_WAIT  = 1,
    parameter int          WR_WAIT  = 0,
    parameter logic [7:0]  OOR_DATA = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_ads_n,
    input  logic                 cpu_rd_n,
    input  logic                 cpu_wr_n,
    input  logic [11:0]          cpu_addr,
    input  logic [7:0]           cpu_d_o,
    output logic [7:0]           cpu_d_i,
    output logic                 hold_n,
    output logic [11:0]          mem_addr,
    output logic [7:0]           mem_d,
    output logic [N_BANKS-1:0]   mem_sel,
    output logic                 mem_rden,
    output logic                 mem_wren,
    input  logic [8*N_BANKS-1:0] mem_q,
    output logic [3:0]           flags,
    output logic                 bus_err,
    input  logic                 err_clr
);

    bus_state_t          state, nxt_state;
    logic [WAIT_W-1:0]   cnt, nxt_cnt, load;
    logic                is_read, nxt_read;
    logic [PAGE_W-1:0]   page;
    logic [PAGE_W-1:0]   acc_page, nxt_acc_page, strobe_page;
    logic [11:0]         nxt_addr;
    logic [7:0]          nxt_d;
    logic                nxt_hold_n, nxt_rden, nxt_wren;
    logic [N_BANKS-1:0]  nxt_sel, onehot;
    logic                rd, wr;
    logic                set_err;
    logic                acc_in_range, wr_ok;
    logic [7:0]          q_sel;

    always_comb begin
        rd          = ~cpu_rd_n;
        wr          = ~cpu_wr_n;
        // An ADS in the same cycle as the strobe overrides the retained page
        strobe_page = cpu_ads_n ? page : cpu_d_o[PAGE_W-1:0];
        load        = rd ? WAIT_W'(RD_WAIT) : WAIT_W'(WR_WAIT);

        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_read     = is_read;
        nxt_acc_page = acc_page;
        nxt_addr     = mem_addr;
        nxt_d        = mem_d;
        set_err      = 1'b0;

        case (state)
            IDLE: begin
                if (rd && wr) begin
                    set_err   = 1'b1;
                    nxt_state = DONE;
                end else if (rd || wr) begin
                    nxt_addr     = cpu_addr;
                    nxt_d        = cpu_d_o;
                    nxt_read     = rd;
                    nxt_acc_page = strobe_page;
                    nxt_cnt      = load;
                    nxt_state    = (load != '0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                nxt_cnt = cnt - 1'b1;
                if (cnt <= WAIT_W'(1)) begin
                    nxt_state = ACCESS;
                end
            end
            ACCESS:  nxt_state = is_read ? CAPTURE : DONE;
            CAPTURE: nxt_state = DONE;
            DONE: begin
                // Released strobes (even during WAIT) let DONE exit at once
                if (cpu_rd_n && cpu_wr_n) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        // Bank decode for the page the upcoming ACCESS will use
        acc_in_range = 32'(nxt_acc_page) < N_BANKS;
        wr_ok        = acc_in_range && RAM_MASK[nxt_acc_page];
        onehot       = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            if (nxt_acc_page == PAGE_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end

        // Moore outputs are registered from the next state
        nxt_hold_n = !(nxt_state inside {WAIT, ACCESS, CAPTURE});
        nxt_rden   = (nxt_state == ACCESS) && nxt_read;
        nxt_wren   = (nxt_state == ACCESS) && !nxt_read && wr_ok;
        nxt_sel    = (nxt_rden || nxt_wren) ? onehot : '0;
        if ((nxt_state == ACCESS) && !nxt_read && !wr_ok) begin
            set_err = 1'b1;
        end

        // Out-of-range pages fall through to OOR_DATA
        q_sel = OOR_DATA;
        for (int i = 0; i < N_BANKS; i++) begin
            if (acc_page == PAGE_W'(i)) begin
                q_sel = mem_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_read  <= 1'b0;
            page     <= '0;
            acc_page <= '0;
            flags    <= '0;
            mem_addr <= '0;
            mem_d    <= '0;
            hold_n   <= 1'b1;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            mem_sel  <= '0;
            cpu_d_i  <= '0;
            bus_err  <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            is_read  <= nxt_read;
            acc_page <= nxt_acc_page;
            mem_addr <= nxt_addr;
            mem_d    <= nxt_d;
            hold_n   <= nxt_hold_n;
            mem_rden <= nxt_rden;
            mem_wren <= nxt_wren;
            mem_sel  <= nxt_sel;
            if (!cpu_ads_n) begin
                page  <= cpu_d_o[PAGE_W-1:0];
                flags <= cpu_d_o[7:4];
            end
            if (state == CAPTURE) begin
                cpu_d_i <= q_sel;
            end
            // A new error wins over a simultaneous clear
            if (set_err) begin
                bus_err <= 1'b1;
            end else if (err_clr) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule
